mesh_edge_ni: RTL and testbench

//  Network interface for one mesh edge port: the upstream/downstream stage for a single

---
 rtl/noc_types_pkg.sv | 30 +++
 rtl/ni_fifo.sv | 55 +++++
 rtl/mesh_edge_ni.sv | 154 +++++++++++++++
 tb/tb_mesh_edge_ni.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_types_pkg.sv
// Shared NoC types for the mesh edge network interface: default field widths,
// flit layout and ejection FSM state encoding.
package noc_types;

  localparam int unsigned NOC_COORD_W = 4;
  localparam int unsigned NOC_DATA_W  = 32;
  localparam int unsigned NOC_FLIT_W  = 2 * NOC_COORD_W + NOC_DATA_W;

  typedef struct packed {
    logic [NOC_COORD_W-1:0] dest_x;
    logic [NOC_COORD_W-1:0] dest_y;
    logic [NOC_DATA_W-1:0]  payload;
  } flit_t;

  typedef enum logic {
    EJ_IDLE = 1'b0,
    EJ_FULL = 1'b1
  } ej_state_t;

  function automatic flit_t make_flit(input logic [NOC_COORD_W-1:0] x,
                                      input logic [NOC_COORD_W-1:0] y,
                                      input logic [NOC_DATA_W-1:0]  d);
    flit_t f;
    f.dest_x  = x;
    f.dest_y  = y;
    f.payload = d;
    return f;
  endfunction

endpackage

// File: rtl/ni_fifo.sv
// Synchronous FIFO with valid/ready on both sides; ready reflects the registered
// occupancy count, so a full FIFO refuses a push even when a pop occurs that cycle.
module ni_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push;
  logic             pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/mesh_edge_ni.sv
// Network interface for one mesh edge port: injection FIFO toward the mesh and a
// one-entry ejection hold register. Optional statistics counters under NI_STATS_EN.
module mesh_edge_ni
  import noc_types::*;
#(
  parameter int unsigned DATA_WIDTH = NOC_DATA_W,
  parameter int unsigned COORD_W    = NOC_COORD_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MY_X       = 0,
  parameter int unsigned MY_Y       = 1,
  parameter int unsigned FLIT_W     = 2 * COORD_W + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inj_valid,
  input  logic [COORD_W-1:0]    inj_dest_x,
  input  logic [COORD_W-1:0]    inj_dest_y,
  input  logic [DATA_WIDTH-1:0] inj_data,
  output logic                  inj_ready,
  output logic                  mesh_out_valid,
  output logic [FLIT_W-1:0]     mesh_out_flit,
  input  logic                  mesh_out_ready,
  input  logic                  mesh_in_valid,
  input  logic [FLIT_W-1:0]     mesh_in_flit,
  output logic                  mesh_in_ready,
  output logic                  ej_valid,
  output logic [DATA_WIDTH-1:0] ej_data,
  input  logic                  ej_ready,
  output logic                  misroute
`ifdef NI_STATS_EN
  ,
  output logic [15:0]           stat_inj_cnt,
  output logic [15:0]           stat_ej_cnt,
  output logic [15:0]           stat_drop_cnt
`endif
);

  localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

  // Held low through reset and set on the first clock after release, so both
  // ready outputs stay low while rst is asserted.
  logic alive;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  logic fifo_in_ready;

  ni_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inj_valid && alive),
    .in_data   ({inj_dest_x, inj_dest_y, inj_data}),
    .in_ready  (fifo_in_ready),
    .out_valid (mesh_out_valid),
    .out_data  (mesh_out_flit),
    .out_ready (mesh_out_ready)
  );

  assign inj_ready = alive && fifo_in_ready;

  logic [COORD_W-1:0]    in_dest_x;
  logic [COORD_W-1:0]    in_dest_y;
  logic [DATA_WIDTH-1:0] in_payload;
  logic                  dest_match;

  assign in_dest_x  = mesh_in_flit[FLIT_W-1 -: COORD_W];
  assign in_dest_y  = mesh_in_flit[DATA_WIDTH +: COORD_W];
  assign in_payload = mesh_in_flit[DATA_WIDTH-1:0];
  assign dest_match = (in_dest_x == MY_X_C) && (in_dest_y == MY_Y_C);

  ej_state_t state;
  ej_state_t state_next;
  logic      load;
  logic      misroute_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EJ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    mesh_in_ready = 1'b0;
    ej_valid      = 1'b0;
    load          = 1'b0;
    misroute_next = 1'b0;
    case (state)
      EJ_IDLE: begin
        mesh_in_ready = alive;
        if (mesh_in_valid && alive) begin
          if (dest_match) begin
            load       = 1'b1;
            state_next = EJ_FULL;
          end else begin
            misroute_next = 1'b1;
          end
        end
      end
      EJ_FULL: begin
        ej_valid = 1'b1;
        if (ej_ready) begin
          state_next = EJ_IDLE;
        end
      end
      default: state_next = EJ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ej_data  <= '0;
      misroute <= 1'b0;
    end else begin
      misroute <= misroute_next;
      if (load) begin
        ej_data <= in_payload;
      end
    end
  end

`ifdef NI_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_inj_cnt  <= '0;
      stat_ej_cnt   <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (mesh_out_valid && mesh_out_ready && (stat_inj_cnt != '1)) begin
        stat_inj_cnt <= stat_inj_cnt + 16'd1;
      end
      if (ej_valid && ej_ready && (stat_ej_cnt != '1)) begin
        stat_ej_cnt <= stat_ej_cnt + 16'd1;
      end
      if (misroute && (stat_drop_cnt != '1)) begin
        stat_drop_cnt <= stat_drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mesh_edge_ni.sv
// Scoreboard bench for mesh_edge_ni: expected flits/payloads are queued as stimulus
// is accepted and compared as the DUT presents them. Covers NI_STATS_EN when defined.
module tb_mesh_edge_ni;
  import noc_types::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW    = 2 * CW + DW;
  localparam int unsigned MYX   = 0;
  localparam int unsigned MYY   = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          inj_valid;
  logic [CW-1:0] inj_dest_x;
  logic [CW-1:0] inj_dest_y;
  logic [DW-1:0] inj_data;
  logic          inj_ready;
  logic          mesh_out_valid;
  logic [FW-1:0] mesh_out_flit;
  logic          mesh_out_ready;
  logic          mesh_in_valid;
  logic [FW-1:0] mesh_in_flit;
  logic          mesh_in_ready;
  logic          ej_valid;
  logic [DW-1:0] ej_data;
  logic          ej_ready;
  logic          misroute;
`ifdef NI_STATS_EN
  logic [15:0]   stat_inj_cnt;
  logic [15:0]   stat_ej_cnt;
  logic [15:0]   stat_drop_cnt;
`endif

  always #5 clk = ~clk;

  mesh_edge_ni #(
    .DATA_WIDTH (DW),
    .COORD_W    (CW),
    .FIFO_DEPTH (DEPTH),
    .MY_X       (MYX),
    .MY_Y       (MYY)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .inj_valid      (inj_valid),
    .inj_dest_x     (inj_dest_x),
    .inj_dest_y     (inj_dest_y),
    .inj_data       (inj_data),
    .inj_ready      (inj_ready),
    .mesh_out_valid (mesh_out_valid),
    .mesh_out_flit  (mesh_out_flit),
    .mesh_out_ready (mesh_out_ready),
    .mesh_in_valid  (mesh_in_valid),
    .mesh_in_flit   (mesh_in_flit),
    .mesh_in_ready  (mesh_in_ready),
    .ej_valid       (ej_valid),
    .ej_data        (ej_data),
    .ej_ready       (ej_ready),
    .misroute       (misroute)
`ifdef NI_STATS_EN
    ,
    .stat_inj_cnt   (stat_inj_cnt),
    .stat_ej_cnt    (stat_ej_cnt),
    .stat_drop_cnt  (stat_drop_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [FW-1:0] inj_q[$];
  logic [DW-1:0] ej_q[$];
  int            mcnt;
  bit            alive;
  bit            m_full;
  bit            m_mis;
  int            m_inj;
  int            m_ej;
  int            m_drop;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already set: checks outputs, advances one edge.
  task automatic cycle();
    bit    exp_ir;
    bit    push;
    bit    pop;
    bit    acc;
    bit    take;
    bit    match;
    flit_t fin;
    exp_ir = alive && (mcnt < DEPTH);
    check("inj_ready", inj_ready, exp_ir);
    check("out_valid", mesh_out_valid, mcnt != 0);
    if (mcnt != 0) check("out_flit", mesh_out_flit, inj_q[0]);
    else if (!rst) check("out_flit_rst", mesh_out_flit, 0);
    check("in_ready", mesh_in_ready, alive && !m_full);
    check("ej_valid", ej_valid, m_full);
    if (m_full) check("ej_data", ej_data, ej_q[0]);
    else if (!rst) check("ej_data_rst", ej_data, 0);
    check("misroute", misroute, m_mis);
`ifdef NI_STATS_EN
    check("stat_inj", stat_inj_cnt, m_inj);
    check("stat_ej", stat_ej_cnt, m_ej);
    check("stat_drop", stat_drop_cnt, m_drop);
`endif
    push  = inj_valid && exp_ir;
    pop   = (mcnt != 0) && mesh_out_ready;
    fin   = mesh_in_flit;
    acc   = mesh_in_valid && alive && !m_full;
    match = (fin.dest_x == CW'(MYX)) && (fin.dest_y == CW'(MYY));
    take  = m_full && ej_ready;
    @(posedge clk);
    if (pop) begin
      void'(inj_q.pop_front());
      m_inj++;
    end
    if (push) inj_q.push_back({inj_dest_x, inj_dest_y, inj_data});
    mcnt = mcnt + int'(push) - int'(pop);
    if (m_mis) m_drop++;
    m_mis = acc && !match;
    if (take) begin
      void'(ej_q.pop_front());
      m_full = 1'b0;
      m_ej++;
    end
    if (acc && match) begin
      ej_q.push_back(fin.payload);
      m_full = 1'b1;
    end
    alive = rst;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    inj_q.delete();
    ej_q.delete();
    mcnt   = 0;
    alive  = 1'b0;
    m_full = 1'b0;
    m_mis  = 1'b0;
    m_inj  = 0;
    m_ej   = 0;
    m_drop = 0;
    repeat (n) cycle();
    rst       = 1'b1;
    inj_valid = 1'b0;
    cycle();
  endtask

  initial begin
    rst            = 1'b1;
    inj_valid      = 1'b0;
    inj_dest_x     = '0;
    inj_dest_y     = '0;
    inj_data       = '0;
    mesh_out_ready = 1'b0;
    mesh_in_valid  = 1'b0;
    mesh_in_flit   = '0;
    ej_ready       = 1'b0;
    @(negedge clk);

    // Reset held 5 cycles with a producer asserting valid
    inj_valid = 1'b1;
    inj_data  = 32'hDEAD_BEEF;
    do_reset(5);

    // Single injection, 1-cycle latency
    inj_valid = 1'b1; inj_dest_x = 4'd2; inj_dest_y = 4'd3; inj_data = 32'hA5A5_0001;
    mesh_out_ready = 1'b1;
    cycle();
    inj_valid = 1'b0;
    check("first_flit", mesh_out_flit, {4'd2, 4'd3, 32'hA5A5_0001});
    cycle();
    cycle();

    // Fill with sink stalled: 5 offered, 4 accepted
    mesh_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inj_valid  = 1'b1;
      inj_dest_x = CW'(i + 1);
      inj_dest_y = CW'(i + 2);
      inj_data   = 32'h1000_0000 + DW'(i);
      cycle();
    end
    check("full_refuse", inj_ready, 0);
    // Full with pop and push in the same cycle: pop wins, push refused
    inj_data = 32'hBAD0_0000;
    mesh_out_ready = 1'b1;
    cycle();
    inj_valid = 1'b0;
    check("count3_ready", inj_ready, 1);
    repeat (4) cycle();

    // Ejection to this node with consumer stalled
    mesh_in_flit  = make_flit(CW'(MYX), CW'(MYY), 32'h0000_1234);
    mesh_in_valid = 1'b1;
    ej_ready      = 1'b0;
    cycle();
    mesh_in_flit  = make_flit(CW'(MYX), CW'(MYY), 32'h0000_9999);
    repeat (3) cycle();
    ej_ready = 1'b1;
    cycle();
    mesh_in_valid = 1'b0;
    ej_ready      = 1'b0;
    cycle();

    // Misrouted flit dropped with a one-cycle pulse
    mesh_in_flit  = make_flit(4'd5, 4'd5, 32'h5555_AAAA);
    mesh_in_valid = 1'b1;
    cycle();
    mesh_in_valid = 1'b0;
    check("misroute_pulse", misroute, 1);
`ifdef NI_STATS_EN
    cycle();
    check("drop_cnt_1", stat_drop_cnt, 1);
`endif
    cycle();
    cycle();

    // Randomised traffic on both paths
    for (int i = 0; i < 300; i++) begin
      inj_valid      = 1'($urandom_range(0, 1));
      inj_dest_x     = CW'($urandom_range(0, 15));
      inj_dest_y     = CW'($urandom_range(0, 15));
      inj_data       = $urandom;
      mesh_out_ready = ($urandom_range(0, 3) != 0);
      mesh_in_valid  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        mesh_in_flit = make_flit(CW'($urandom_range(2, 15)), CW'($urandom_range(0, 15)), $urandom);
      else
        mesh_in_flit = make_flit(CW'(MYX), CW'(MYY), $urandom);
      ej_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    // Reset mid-traffic discards held flits
    mesh_out_ready = 1'b0;
    ej_ready       = 1'b0;
    inj_valid      = 1'b1;
    mesh_in_valid  = 1'b1;
    mesh_in_flit   = make_flit(CW'(MYX), CW'(MYY), 32'hCAFE_0001);
    repeat (3) cycle();
    mesh_in_valid = 1'b0;
    do_reset(2);
    inj_valid = 1'b0;
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
